// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: walks one active-low column at a time, debounces a
// single-row press, emits one code per press and keeps the last four codes.
module hex_keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned DEBOUNCE_CNT = 250000
) (
   input  logic        clk,
   input  logic        notrst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] digits
);

   localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DEB_W   = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);
   localparam logic [3:0]         ROW_IDLE   = 4'b1111;
   localparam logic [3:0]         COL_FIRST  = 4'b1110;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [3:0]         row_m, row_s;
   logic [DWELL_W-1:0] dwell, dwell_nxt;
   logic [DEB_W-1:0]   cnt, cnt_nxt;
   logic [3:0]         pat, pat_nxt;
   logic [3:0]         col_nxt;
   logic [3:0]         key_nxt;
   logic               key_valid_nxt;
   logic               key_held_nxt;
   logic [15:0]        digits_nxt;

   logic [3:0]         col_rot;
   logic [3:0]         code;

   // True when exactly one line of a one-cold candidate is low.
   function automatic logic single_low(input logic [3:0] v);
      logic res;
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
         default:                            res = 1'b0;
      endcase
      return res;
   endfunction

   // Index of the low line of a one-cold vector.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Next column in the 1110 -> 1101 -> 1011 -> 0111 rotation, and the code of
   // the latched press on the frozen column.
   always_comb begin
      col_rot = {col[2:0], col[3]};
      code    = {low_idx(pat), low_idx(col)};
   end

   // Two-flop synchroniser for the asynchronous row lines.
   always_ff @(posedge clk or negedge notrst) begin
      if (!notrst) begin
         row_m <= ROW_IDLE;
         row_s <= ROW_IDLE;
      end else begin
         row_m <= row;
         row_s <= row_m;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge notrst) begin
      if (!notrst) begin
         state     <= ST_SCAN;
         dwell     <= '0;
         cnt       <= '0;
         pat       <= ROW_IDLE;
         col       <= COL_FIRST;
         key       <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         digits    <= '0;
      end else begin
         state     <= state_nxt;
         dwell     <= dwell_nxt;
         cnt       <= cnt_nxt;
         pat       <= pat_nxt;
         col       <= col_nxt;
         key       <= key_nxt;
         key_valid <= key_valid_nxt;
         key_held  <= key_held_nxt;
         digits    <= digits_nxt;
      end
   end

   // Scan / debounce / held sequencing and next output values.
   always_comb begin
      state_nxt     = state;
      dwell_nxt     = dwell;
      cnt_nxt       = cnt;
      pat_nxt       = pat;
      col_nxt       = col;
      key_nxt       = key;
      key_valid_nxt = 1'b0;
      key_held_nxt  = key_held;
      digits_nxt    = digits;

      case (state)
         ST_SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_nxt = '0;
               if (single_low(row_s)) begin
                  pat_nxt   = row_s;
                  cnt_nxt   = '0;
                  state_nxt = ST_DEBOUNCE;
               end else begin
                  col_nxt = col_rot;
               end
            end else begin
               dwell_nxt = dwell + DWELL_W'(1);
            end
         end

         ST_DEBOUNCE: begin
            if (row_s != pat) begin
               col_nxt   = col_rot;
               dwell_nxt = '0;
               cnt_nxt   = '0;
               state_nxt = ST_SCAN;
            end else if (cnt == DEB_LAST) begin
               key_valid_nxt = 1'b1;
               key_nxt       = code;
               digits_nxt    = {digits[11:0], code};
               key_held_nxt  = 1'b1;
               cnt_nxt       = '0;
               state_nxt     = ST_HELD;
            end else begin
               cnt_nxt = cnt + DEB_W'(1);
            end
         end

         ST_HELD: begin
            if (row_s != ROW_IDLE) begin
               cnt_nxt = '0;
            end else if (cnt == DEB_LAST) begin
               key_held_nxt = 1'b0;
               col_nxt      = col_rot;
               dwell_nxt    = '0;
               cnt_nxt      = '0;
               state_nxt    = ST_SCAN;
            end else begin
               cnt_nxt = cnt + DEB_W'(1);
            end
         end

         default: begin
            state_nxt = ST_SCAN;
            dwell_nxt = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Input-side counterpart of the 4-digit multiplexed 7-segment display driver.
- Scans a 4x4 hex keypad by driving one active-low column at a time and reading four active-low row lines.
- Debounces presses and emits one 4-bit hex code per press.
- Keeps a 16-bit shift register of the last four keys, which the display driver can show directly as h3..h0.

Parameters:
- SCAN_DIV, 50000, clock cycles each column is driven (dwell time); must be >= 2.
- DEBOUNCE_CNT, 250000, consecutive stable cycles required to accept a press or release; must be >= 1.

Ports:
- clk  input  1  system clock.
- notrst  input  1  reset, asynchronous, active-low.
- row  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col  output  4  keypad column drive, active-low, exactly one bit low at all times.
- key  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key remains pressed, including its release debounce.
- digits  output  16  last four keys; digits[3:0] is the newest.

Behaviour:
- Reset: clk and one active-low reset, notrst, asynchronous assert, synchronous release. While notrst=0, all state clears immediately:
  - col=4'b1110, key=0, key_valid=0, key_held=0, digits=0.
  - FSM in SCAN; dwell and debounce counters at 0; synchroniser flops at 4'b1111.
- row passes through a 2-flop synchroniser to give row_s. All decisions use row_s only.
- Key code = 4*row_idx + col_idx, i.e. {row_idx[1:0], col_idx[1:0]}:
  - row_idx: index of the low row_s bit (row[0] is index 0).
  - col_idx: index of the low col bit.
- "Single press": exactly one bit of row_s is 0. Zero or two or more low bits count as no press (ghosting is rejected).
- State SCAN:
  - Dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, row_s is sampled.
    - Single press: latch pattern P=row_s, hold col unchanged, go to DEBOUNCE with cnt=0.
    - Otherwise: col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 and the dwell counter restarts.
- State DEBOUNCE (col frozen):
  - Each cycle, if row_s != P: go to SCAN; col advances to the next column; dwell restarts at 0; no output.
  - Otherwise cnt increments.
  - On the cycle cnt == DEBOUNCE_CNT-1 with row_s == P, at the same edge:
    - key_valid=1 (for that one cycle only).
    - key = code.
    - digits = {digits[11:0], code}.
    - key_held = 1.
    - Go to HELD with cnt=0.
  - key_valid therefore rises DEBOUNCE_CNT cycles after entering DEBOUNCE.
- State HELD (col frozen, key_held=1):
  - cnt counts consecutive cycles with row_s == 4'b1111; any low bit resets cnt to 0.
  - A changing or additional row never produces a new key.
  - When cnt reaches DEBOUNCE_CNT-1 with row_s all high: key_held=0, go to SCAN; col advances to the next column; dwell restarts.
- Exactly one key_valid pulse per accepted press. A held key never auto-repeats.
- key and digits change only on key_valid. They hold their value otherwise, including across rejected presses.
- Counter widths: dwell uses $clog2(SCAN_DIV) bits; debounce uses $clog2(DEBOUNCE_CNT) bits, minimum 1. No overflow is possible because the counters saturate by state exit.
- Reset asserted mid-operation, in any state: outputs clear immediately and a pending press is discarded. After release, scanning restarts from column 0. A key still held at release is detected normally as a fresh press.

Test Plan:
Bench setup: SCAN_DIV=4, DEBOUNCE_CNT=8. The keypad model drives row[r]=0 iff key (r,c) is pressed and col[c]=0.
1. Reset: notrst=0 mid-scan -> col=1110, key=0, digits=16'h0000, key_valid=0 with no clock edge needed. After release, col steps 1110, 1101, 1011, 0111, 1110, changing every 4 clocks.
2. Press key 6 (row1, col2) for 100 cycles, then release:
   - exactly one key_valid pulse, key=4'h6, digits=16'h0006;
   - the pulse occurs 8 cycles after DEBOUNCE entry;
   - col stays at 1011 while held;
   - key_held falls 8 stable-high cycles (plus sync) after release, then col moves to 0111.
3. Bounce: key 6 toggled with 5-cycle low/high intervals for 60 cycles -> no key_valid, key and digits unchanged, scanning resumes.
4. Sequence: keys 1, A, F, 0, each pressed 40 cycles and released 40 cycles -> 4 pulses; digits=16'h1AF0, key=4'h0.
5. Ghost: keys 2 and 6 (same column 2, rows 0 and 1) held together for 100 cycles -> no key_valid, col keeps rotating.
6. Reset in HELD: key 9 accepted, then notrst pulsed low while still held -> key_held=0 and digits=0 immediately. After release of notrst with key 9 still pressed -> one new pulse, key=4'h9, digits=16'h0009.
